// File: rtl/adder_share_arb.sv
// adder_share_arb
// Arbitrates two add requesters onto one shared external 4-bit adder.
// Each add takes a fixed three cycles: grant in IDLE, sample the adder in
// CALC, then report with a one-cycle ack in DONE.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no add in flight; arbitrate and latch winner operands
//   CALC  | adder settled on latched operands; capture sum and carry
//   DONE  | ack pulse to granted requester; result valid
module adder_share_arb #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    input  logic [3:0] add_sum,
    input  logic       add_cout,
    output logic       ack0,
    output logic       ack1,
    output logic [4:0] result,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   grant;       // requester owning the in-flight add (0 or 1)
    logic   last_grant;  // requester granted most recently
    logic   pick;        // arbitration winner for the current IDLE cycle

    // Winner selection: a lone requester always wins; on a tie either
    // requester 0 (fixed priority) or the one not served last.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            if (FIXED_PRIO != 0) begin
                pick = 1'b0;
            end else begin
                pick = ~last_grant;
            end
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // Sequencer: grant, capture, acknowledge. Operands are frozen into
    // add_a/add_b at the grant edge so later requester changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            add_a      <= 4'd0;
            add_b      <= 4'd0;
            result     <= 5'd0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant      <= pick;
                        last_grant <= pick;
                        add_a      <= pick ? a1 : a0;
                        add_b      <= pick ? b1 : b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    result <= {add_cout, add_sum};
                    ack0   <= ~grant;
                    ack1   <= grant;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Any add in flight counts as busy.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: one round-robin and one fixed-priority instance
// driven side by side, each with its own adder model and requester pair,
// checked every cycle against a transaction-level schedule model.
module tb_adder_share_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0   [2];
    logic       req1   [2];
    logic [3:0] a0     [2];
    logic [3:0] b0     [2];
    logic [3:0] a1     [2];
    logic [3:0] b1     [2];
    logic [3:0] add_a  [2];
    logic [3:0] add_b  [2];
    logic [3:0] add_sum[2];
    logic       add_cout[2];
    logic       ack0   [2];
    logic       ack1   [2];
    logic [4:0] result [2];
    logic       busy   [2];

    // Shared external adders, one per instance
    assign {add_cout[0], add_sum[0]} = {1'b0, add_a[0]} + {1'b0, add_b[0]};
    assign {add_cout[1], add_sum[1]} = {1'b0, add_a[1]} + {1'b0, add_b[1]};

    adder_share_arb #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst),
        .req0(req0[0]), .a0(a0[0]), .b0(b0[0]),
        .req1(req1[0]), .a1(a1[0]), .b1(b1[0]),
        .add_a(add_a[0]), .add_b(add_b[0]),
        .add_sum(add_sum[0]), .add_cout(add_cout[0]),
        .ack0(ack0[0]), .ack1(ack1[0]),
        .result(result[0]), .busy(busy[0])
    );

    adder_share_arb #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0[1]), .a0(a0[1]), .b0(b0[1]),
        .req1(req1[1]), .a1(a1[1]), .b1(b1[1]),
        .add_a(add_a[1]), .add_b(add_b[1]),
        .add_sum(add_sum[1]), .add_cout(add_cout[1]),
        .ack0(ack0[1]), .ack1(ack1[1]),
        .result(result[1]), .busy(busy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit rand_en = 1'b0;

    // Schedule model: an add granted in cycle g reports in g+2 and the
    // adder is free to grant again from g+3.
    int         gcyc   [2];
    int         win    [2];
    int         last   [2];
    logic [3:0] pa     [2];
    logic [3:0] pb     [2];
    logic [4:0] pend   [2];
    logic [4:0] exp_res[2];

    // Values observed at the most recent sampling point
    logic       cap_ack0[2];
    logic       cap_ack1[2];
    logic       cap_busy[2];
    logic [4:0] cap_res [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_winner(input int d);
        if (req0[d] && req1[d]) begin
            if (d == 1) return 0;
            return (last[d] == 1) ? 0 : 1;
        end
        if (req0[d]) return 0;
        return 1;
    endfunction

    // One clock cycle: sample and check at the falling edge, advance the
    // model, then update requesters just after the rising edge.
    task automatic step();
        logic e_ack0, e_ack1, e_busy;
        int   w;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            e_ack0 = (gcyc[d] == cyc - 2) && (win[d] == 0);
            e_ack1 = (gcyc[d] == cyc - 2) && (win[d] == 1);
            if (gcyc[d] == cyc - 2) exp_res[d] = pend[d];
            e_busy = (cyc == gcyc[d] + 1) || (cyc == gcyc[d] + 2);
            check($sformatf("d%0d_ack0", d), ack0[d], e_ack0);
            check($sformatf("d%0d_ack1", d), ack1[d], e_ack1);
            check($sformatf("d%0d_busy", d), busy[d], e_busy);
            check($sformatf("d%0d_result", d), result[d], exp_res[d]);
            if (e_busy) begin
                check($sformatf("d%0d_add_a", d), add_a[d], pa[d]);
                check($sformatf("d%0d_add_b", d), add_b[d], pb[d]);
            end
            cap_ack0[d] = ack0[d];
            cap_ack1[d] = ack1[d];
            cap_busy[d] = busy[d];
            cap_res[d]  = result[d];
            if (rst) begin
                gcyc[d]    = -100;
                exp_res[d] = 5'd0;
                last[d]    = 1;
            end else if (cyc >= gcyc[d] + 3 && (req0[d] || req1[d])) begin
                w       = pick_winner(d);
                gcyc[d] = cyc;
                win[d]  = w;
                pa[d]   = (w == 1) ? a1[d] : a0[d];
                pb[d]   = (w == 1) ? b1[d] : b0[d];
                pend[d] = {1'b0, pa[d]} + {1'b0, pb[d]};
                last[d] = w;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (cap_ack0[d]) req0[d] = 1'b0;
            if (cap_ack1[d]) req1[d] = 1'b0;
            if (rand_en) begin
                if (!req0[d] && $urandom_range(0, 3) != 0) begin
                    req0[d] = 1'b1;
                    a0[d]   = 4'($urandom_range(0, 15));
                    b0[d]   = 4'($urandom_range(0, 15));
                end
                if (!req1[d] && $urandom_range(0, 1) != 0) begin
                    req1[d] = 1'b1;
                    a1[d]   = 4'($urandom_range(0, 15));
                    b1[d]   = 4'($urandom_range(0, 15));
                end
                // Disturb the operands of an add already in flight
                if (cyc <= gcyc[d] + 2 && $urandom_range(0, 1) != 0) begin
                    if (win[d] == 0) begin
                        a0[d] = 4'($urandom_range(0, 15));
                        b0[d] = 4'($urandom_range(0, 15));
                    end else begin
                        a1[d] = 4'($urandom_range(0, 15));
                        b1[d] = 4'($urandom_range(0, 15));
                    end
                end
            end
        end
        if (rand_en) rst = ($urandom_range(0, 59) == 0);
    endtask

    task automatic set_req0(input logic [3:0] a, input logic [3:0] b);
        for (int d = 0; d < 2; d++) begin
            req0[d] = 1'b1;
            a0[d]   = a;
            b0[d]   = b;
        end
    endtask

    task automatic set_req1(input logic [3:0] a, input logic [3:0] b);
        for (int d = 0; d < 2; d++) begin
            req1[d] = 1'b1;
            a1[d]   = a;
            b1[d]   = b;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req0[d] = 1'b0; req1[d] = 1'b0;
            a0[d] = 4'd0; b0[d] = 4'd0; a1[d] = 4'd0; b1[d] = 4'd0;
            gcyc[d] = -100; win[d] = 0; last[d] = 1;
            pa[d] = 4'd0; pb[d] = 4'd0; pend[d] = 5'd0; exp_res[d] = 5'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_rst_busy", d), cap_busy[d], 1'b0);
            check($sformatf("d%0d_rst_result", d), cap_res[d], 5'd0);
            check($sformatf("d%0d_rst_add_a", d), add_a[d], 4'd0);
            check($sformatf("d%0d_rst_add_b", d), add_b[d], 4'd0);
        end
        rst = 1'b0;

        // Tie straight after reset: requester 0 first, requester 1 three cycles later
        set_req0(4'd6, 4'd6);
        set_req1(4'd5, 4'd3);
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_tie_ack0", d), cap_ack0[d], 1'b1);
            check($sformatf("d%0d_tie_res0", d), cap_res[d], 5'd12);
        end
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_tie_ack1", d), cap_ack1[d], 1'b1);
            check($sformatf("d%0d_tie_noack0", d), cap_ack0[d], 1'b0);
            check($sformatf("d%0d_tie_res1", d), cap_res[d], 5'd8);
        end
        repeat (2) step();

        // Single add with carry out
        set_req0(4'd6, 4'd10);
        step();
        step();
        check("single_busy", cap_busy[0], 1'b1);
        step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_single_ack0", d), cap_ack0[d], 1'b1);
            check($sformatf("d%0d_single_ack1", d), cap_ack1[d], 1'b0);
            check($sformatf("d%0d_single_res", d), cap_res[d], 5'h10);
        end
        repeat (2) step();

        // Requester 1 alone
        set_req1(4'd2, 4'd7);
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_r1_ack1", d), cap_ack1[d], 1'b1);
            check($sformatf("d%0d_r1_res", d), cap_res[d], 5'd9);
        end
        repeat (2) step();

        // Operand change after the grant edge is ignored
        set_req0(4'd8, 4'd5);
        step();
        for (int d = 0; d < 2; d++) a0[d] = 4'd15;
        repeat (2) step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_stable_res", d), cap_res[d], 5'd13);
        end
        repeat (2) step();

        // Reset during CALC discards the add; the held request is served after
        set_req0(4'd8, 4'd5);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            a0[d] = 4'd15;
            b0[d] = 4'd1;
        end
        step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_midrst_ack0", d), cap_ack0[d], 1'b0);
            check($sformatf("d%0d_midrst_busy", d), cap_busy[d], 1'b0);
            check($sformatf("d%0d_midrst_res", d), cap_res[d], 5'd0);
        end
        repeat (2) step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_after_rst_ack0", d), cap_ack0[d], 1'b1);
            check($sformatf("d%0d_after_rst_res", d), cap_res[d], 5'h10);
        end
        repeat (2) step();

        // Tie after requester 0 was last served: round-robin picks 1, fixed picks 0
        set_req0(4'd1, 4'd2);
        set_req1(4'd3, 4'd4);
        repeat (3) step();
        check("rr_tie_ack1", cap_ack1[0], 1'b1);
        check("fp_tie_ack0", cap_ack0[1], 1'b1);
        repeat (4) step();

        // Randomised traffic with in-flight operand disturbance and resets
        rand_en = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        rst = 1'b0;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
ADDER_SHARE_ARB -- requirements
Module: adder_share_arb

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin arbitration and 1 = requester 0 always wins ties.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port req0  input  1  requester 0 add request, held high until ack0 is seen.
REQ-005 The block SHALL have port a0, b0  input  4 each  requester 0 operands.
REQ-006 The block SHALL have port req1  input  1  requester 1 add request, held high until ack1 is seen.
REQ-007 The block SHALL have port a1, b1  input  4 each  requester 1 operands.
REQ-008 The block SHALL have port add_a, add_b  output  4 each  operands driven to the shared external 4-bit adder.
REQ-009 The block SHALL have port add_sum  input  4  sum returned by the shared adder.
REQ-010 The block SHALL have port add_cout  input  1  carry-out returned by the shared adder.
REQ-011 The block SHALL have port ack0, ack1  output  1 each  one-cycle completion pulse per requester.
REQ-012 The block SHALL have port result  output  5  {add_cout, add_sum} of the last completed add.
REQ-013 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-015 In IDLE with any req high, the FSM SHALL pick a winner, register its operands into add_a/add_b, record the grant, and go to CALC; with no req it SHALL stay in IDLE.
REQ-016 In CALC, the FSM SHALL capture {add_cout, add_sum} into result and go to DONE.
REQ-017 In DONE, the FSM SHALL assert ack of the granted requester only, for exactly one cycle, then return to IDLE.
REQ-018 Latency SHALL be fixed: req sampled in IDLE cycle n gives CALC in n+1, and ack high with result valid in n+2.
REQ-019 The adder combinational delay SHALL be treated as under one clock period; the adder output is sampled only in CALC.
REQ-020 Arbitration with FIXED_PRIO=0 SHALL be round-robin:
- a last_grant bit is kept;
- on a tie, the requester not last granted wins;
- with a single req, that requester wins regardless of last_grant.
REQ-021 Arbitration with FIXED_PRIO=1 SHALL grant req0 on every tie.
REQ-022 Operand changes after the IDLE grant edge SHALL be ignored; add_a/add_b hold their registered values until the next grant.
REQ-023 Requests arriving while busy SHALL be neither lost nor acked early; they are arbitrated at the next IDLE cycle.
REQ-024 The requester SHALL drop req on the edge at which it samples ack high, so IDLE in n+3 does not re-serve it.
REQ-025 result SHALL hold its value until the next CALC capture.
REQ-026 ack0 and ack1 SHALL never be high in the same cycle.
REQ-027 Carry SHALL NOT wrap: 4'hF + 4'h1 gives result 5'b1_0000.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL:
- set state to IDLE, with busy 0;
- set ack0 and ack1 to 0;
- clear result, add_a and add_b to 0;
- set last_grant to 1, so requester 0 wins the first tie.
REQ-029 Reset asserted in CALC or DONE SHALL discard the in-flight add with no ack issued; requests still high after rst falls are served normally.

Verification
REQ-030 Single add: req0=1, a0=6, b0=10 in IDLE cycle n -> busy in n+1, ack0=1 and result=5'b1_0000 in n+2, ack1=0 throughout.
REQ-031 Requester 1 alone: req1=1, a1=2, b1=7 -> ack1 in n+2, result=5'b0_1001.
REQ-032 Tie, round-robin: after reset, req0 (6+6) and req1 (5+3) raised together in cycle n -> ack0 with result 12 in n+2, then ack1 with result 8 in n+5, with no overlap.
REQ-033 Fixed priority: FIXED_PRIO=1, both requesters re-raise immediately after each ack -> req0 granted on every tie, req1 served only in cycles where req0 is low.
REQ-034 Operand stability: req0 with a0=8, b0=5, then a0 changed to 15 in CALC -> result=5'b0_1101 (13).
REQ-035 Reset mid-operation: rst pulsed for one cycle during CALC -> no ack pulse, result=0, busy=0; a new req0 with 15+1 then gives result=5'b1_0000 two cycles after its IDLE sample.
